// File: rtl/traffic_light_ctrl.sv
// Moore sequencer for a main/side intersection with a pedestrian crossing.
// Optional blinking-walk phase is built when TL_WALK_BLINK_EN is defined.
module traffic_light_ctrl #(
  parameter int unsigned T_BASE  = 6,
  parameter int unsigned T_EXT   = 3,
  parameter int unsigned T_YEL   = 2,
  parameter int unsigned T_WALK  = 5
`ifdef TL_WALK_BLINK_EN
  ,
  parameter int unsigned T_BLINK = 4
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sensor,
  input  logic       walk_req,
  input  logic       expired,
  input  logic       two_hz_enable,
  output logic [4:0] timer_value,
  output logic       timer_start,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk_light
);

  typedef enum logic [2:0] {
    MAIN_GREEN,
    MAIN_YELLOW,
    WALK,
    SIDE_GREEN,
    SIDE_EXT,
    SIDE_YELLOW
`ifdef TL_WALK_BLINK_EN
    ,
    WALK_BLINK
`endif
  } state_e;

  state_e state_q, state_d;
  logic   load_q, load_d;
  logic   walk_pend_q, walk_pend_d;

`ifdef TL_WALK_BLINK_EN
  logic   blink_q, blink_d;
`else
  logic   unused_blink_strobe;
  assign unused_blink_strobe = two_hz_enable;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= MAIN_GREEN;
      load_q      <= 1'b1;
      walk_pend_q <= 1'b0;
`ifdef TL_WALK_BLINK_EN
      blink_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      walk_pend_q <= walk_pend_d;
`ifdef TL_WALK_BLINK_EN
      blink_q     <= blink_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    load_d      = 1'b0;
    walk_pend_d = walk_pend_q;
    // expired is only honoured in RUN; every detection starts a LOAD cycle
    if (!load_q && expired) begin
      load_d = 1'b1;
      unique case (state_q)
        MAIN_GREEN:  state_d = (sensor || walk_pend_q) ? MAIN_YELLOW : MAIN_GREEN;
        MAIN_YELLOW: state_d = walk_pend_q ? WALK : SIDE_GREEN;
`ifdef TL_WALK_BLINK_EN
        WALK:        state_d = WALK_BLINK;
        WALK_BLINK:  state_d = sensor ? SIDE_GREEN : MAIN_GREEN;
`else
        WALK:        state_d = sensor ? SIDE_GREEN : MAIN_GREEN;
`endif
        SIDE_GREEN:  state_d = sensor ? SIDE_EXT : SIDE_YELLOW;
        SIDE_EXT:    state_d = SIDE_YELLOW;
        SIDE_YELLOW: state_d = MAIN_GREEN;
        default:     state_d = MAIN_GREEN;
      endcase
    end
    if (load_q && state_q == WALK) walk_pend_d = 1'b0;
    if (walk_req) walk_pend_d = 1'b1;
`ifdef TL_WALK_BLINK_EN
    // Held at 1 outside the blink phase so the lamp enters WALK_BLINK lit
    blink_d = blink_q;
    if (state_q != WALK_BLINK) blink_d = 1'b1;
    else if (two_hz_enable)    blink_d = ~blink_q;
`endif
  end

  always_comb begin
    timer_start = load_q;
    main_lights = 3'b100;
    side_lights = 3'b100;
    walk_light  = 1'b0;
    timer_value = 5'(T_BASE);
    unique case (state_q)
      MAIN_GREEN: begin
        main_lights = 3'b001;
        timer_value = 5'(T_BASE);
      end
      MAIN_YELLOW: begin
        main_lights = 3'b010;
        timer_value = 5'(T_YEL);
      end
      WALK: begin
        walk_light  = 1'b1;
        timer_value = 5'(T_WALK);
      end
`ifdef TL_WALK_BLINK_EN
      WALK_BLINK: begin
        walk_light  = blink_q;
        timer_value = 5'(T_BLINK);
      end
`endif
      SIDE_GREEN: begin
        side_lights = 3'b001;
        timer_value = 5'(T_BASE);
      end
      SIDE_EXT: begin
        side_lights = 3'b001;
        timer_value = 5'(T_EXT);
      end
      SIDE_YELLOW: begin
        side_lights = 3'b010;
        timer_value = 5'(T_YEL);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Moore state machine that sequences a main/side intersection with a pedestrian crossing. It drives the 5-bit countdown timer through its `value` / `start_timer` / `expired` handshake, one interval per phase. It uses the timer's `two_hz_enable` strobe to blink the walk lamp. It sits between the timer and the lamp/button I/O at the top of the traffic design.

## Interface
- `T_BASE`, default 6: main/side green base interval, seconds (1..31).
- `T_EXT`, default 3: side-green extension when the side sensor is still active (1..31).
- `T_YEL`, default 2: yellow interval (1..31).
- `T_WALK`, default 5: steady walk interval (1..31).
- `T_BLINK`, default 4: blinking walk interval (1..31).
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; all state cleared immediately.
- `sensor`  in  1  side-road vehicle present, level, synchronous.
- `walk_req`  in  1  pedestrian button, synchronous; any high cycle is latched.
- `expired`  in  1  timer interval finished.
- `two_hz_enable`  in  1  timer blink strobe, one cycle wide.
- `timer_value`  out  5  interval for the current phase; valid whenever `timer_start` = 1.
- `timer_start`  out  1  one-cycle load pulse to the timer.
- `main_lights`  out  3  {red, yellow, green}, one-hot.
- `side_lights`  out  3  {red, yellow, green}, one-hot.
- `walk_light`  out  1  pedestrian walk lamp.

## Operation
- States: MAIN_GREEN, MAIN_YELLOW, WALK, WALK_BLINK, SIDE_GREEN, SIDE_EXT, SIDE_YELLOW.
- Each state has two phases: LOAD (one cycle, `timer_start` = 1) then RUN (`timer_start` = 0, wait for `expired`).
- `expired` is sampled only in RUN.
- Transitions happen on the RUN cycle where `expired` = 1. The next cycle is LOAD of the target state.
- MAIN_GREEN (T_BASE):
  - If `sensor` or `walk_pend` is set, go to MAIN_YELLOW.
  - Otherwise reload MAIN_GREEN. Lamps do not change.
- MAIN_YELLOW (T_YEL): go to WALK if `walk_pend`, else SIDE_GREEN.
- WALK (T_WALK): go to WALK_BLINK. All vehicle lamps are red.
- WALK_BLINK (T_BLINK): go to SIDE_GREEN if `sensor`, else MAIN_GREEN.
- SIDE_GREEN (T_BASE): go to SIDE_EXT if `sensor`, else SIDE_YELLOW.
- SIDE_EXT (T_EXT): go to SIDE_YELLOW. The extension is granted at most once per side cycle.
- SIDE_YELLOW (T_YEL): go to MAIN_GREEN.
- Lamps:
  - Main is green/yellow only in MAIN_GREEN/MAIN_YELLOW, red otherwise.
  - Side is green in SIDE_GREEN/SIDE_EXT, yellow in SIDE_YELLOW, red otherwise.
  - Main and side are never simultaneously non-red.
- `walk_light`:
  - 1 in WALK.
  - In WALK_BLINK it toggles on each `two_hz_enable`, starting at 1 on entry.
  - 0 in all other states.
- `walk_pend`:
  - Set by `walk_req`.
  - Cleared in WALK LOAD.
  - If `walk_req` arrives on the clearing cycle, set wins.
  - A request during WALK/WALK_BLINK is kept and serviced in the next main cycle.
- `timer_value` is a combinational decode of the state. It is held constant through the whole state, not only during LOAD.

## Timing
- Reset values:
  - State MAIN_GREEN, phase LOAD, so `timer_start` = 1.
  - `walk_pend` = 0.
  - `main_lights` = 3'b001, `side_lights` = 3'b100, `walk_light` = 0, `timer_value` = T_BASE.
- The first timer load occurs on the first clock edge after reset deasserts.
- Timer handshake: the timer clears `expired` at the LOAD edge, so the first RUN cycle sees `expired` = 0. A stale `expired` from the previous phase is never acted on.
- Phase length: timer interval + 1 LOAD cycle + 1 detection cycle.
- Lamp outputs change on the same edge as the state register; there is no extra output latency.
- `sensor` is evaluated only on the cycle `expired` is seen.
- An asynchronous reset mid-phase forces the reset values immediately; the pending walk is lost.

## Configuration
- `TL_WALK_BLINK_EN` defined: WALK_BLINK is present as specified above.
- `TL_WALK_BLINK_EN` undefined:
  - WALK_BLINK and T_BLINK are removed.
  - WALK applies the WALK_BLINK exit rule directly: SIDE_GREEN if `sensor`, else MAIN_GREEN.
  - `two_hz_enable` is ignored.

## Test plan
- Reset, then `sensor` = 0 and no `walk_req`, with a timer model: MAIN_GREEN reloads forever, `timer_value` = 6, `timer_start` pulses once per phase, `side_lights` stays 3'b100.
- `sensor` = 1 at the end of MAIN_GREEN and held: sequence MAIN_YELLOW(2) → SIDE_GREEN(6) → SIDE_EXT(3) → SIDE_YELLOW(2) → MAIN_GREEN. The extension is granted exactly once.
- `walk_req` pulsed for 1 cycle mid MAIN_GREEN:
  - Sequence MAIN_YELLOW → WALK (`walk_light` = 1, all vehicle lamps red) → WALK_BLINK.
  - In WALK_BLINK, `walk_light` toggles on each `two_hz_enable`.
  - Then MAIN_GREEN, and `walk_pend` = 0.
- `walk_req` asserted on the WALK LOAD cycle: `walk_pend` = 1 after WALK, and a second walk is served in the next main cycle.
- Assert `reset` in the middle of SIDE_EXT: outputs return immediately to the reset values; after release, `timer_start` = 1 with `timer_value` = 6.
- With `TL_WALK_BLINK_EN` undefined and `sensor` = 1 at WALK expiry: the next state is SIDE_GREEN, and `walk_light` drops to 0 at the transition.
